cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Transmit side of the common data bus. Functional units (ALU, branch) hand completed results to this block; it buffers each source and drives one result per cycle onto the CDB.
- Consumers are the reorder buffer and the reservation stations.
- Sits between the execute stage and the CDB broadcast. Flushed by the mispredict clear (controlFlow[0]).

Parameters:
- WIDTH, 31: MSB index of the result bus (result is WIDTH+1 bits).
- ROB, 2: MSB index of the ROB tag.
- CTRL, 1: MSB index of per-result control flags (bit0 = mispredict, bit1 = jump-taken).
- NSRC, 2: number of producing functional units.
- DEPTH, 2: entries per source FIFO; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- globalReset  in  1  reset; synchronous, active-low.
- clear  in  1  synchronous flush (mispredict).
- src_valid  in  NSRC  per-source result-present.
- src_ready  out  NSRC  per-source FIFO-not-full.
- src_result  in  NSRC*(WIDTH+1)  packed results; source i occupies slice i.
- src_rob  in  NSRC*(ROB+1)  packed ROB tags.
- src_ctrl  in  NSRC*(CTRL+1)  packed control flags.
- cdb_accept  in  1  consumer takes the current CDB word.
- cdb_valid  out  1  CDB word present.
- cdb_result  out  WIDTH+1  broadcast result.
- cdb_rob  out  ROB+1  broadcast tag.
- cdb_ctrl  out  CTRL+1  broadcast flags.
- cdb_src  out  $clog2(NSRC)  index of the winning source.

Behaviour:
- Reset (globalReset=0 at posedge):
  - All FIFOs empty.
  - cdb_valid=0; cdb_result, cdb_rob, cdb_ctrl, cdb_src all 0.
  - Round-robin pointer = 0.
  - src_ready = all 1 from the first cycle after reset.
- Reset has priority over clear; clear has priority over push and pop.
- Push:
  - Source i pushes on posedge when src_valid[i] & src_ready[i].
  - src_ready[i] = (count[i] != DEPTH), taken from registered count only.
  - A full FIFO shows ready=0 even in a cycle where it pops.
- Output register:
  - It is free when !cdb_valid | cdb_accept.
  - When free and some FIFO is non-empty, load the arbitration winner's head entry and pop that FIFO. cdb_valid then goes 1.
  - When free and all FIFOs are empty, cdb_valid goes 0 and the data fields hold their value.
  - When cdb_valid & !cdb_accept, all outputs hold, with no pop.
- Arbitration: round-robin over non-empty FIFOs.
  - Search starts at (ptr+1) mod NSRC.
  - ptr is updated to the winner only on a load; it is unchanged otherwise.
- Latency without the optional feature: a push at edge N is visible on the CDB after edge N+1 (2 cycles from src_valid).
- Simultaneous push and pop on the same FIFO: both happen; count is unchanged. Pointers wrap mod DEPTH.
- Clear:
  - Next cycle: all counts 0, cdb_valid=0, ptr=0.
  - Pushes presented in the clear cycle are dropped.
  - src_ready = all 1 the cycle after clear.
- Ordering: order is preserved within a source. No ordering guarantee across sources.

Optional Feature:
- Macro: CDB_BYPASS_EN.
- When defined:
  - If the output register is free and every FIFO is empty (registered), a valid input is loaded directly into the output register, skipping its FIFO. Latency is 1 cycle (edge N push, visible after edge N).
  - If several sources are valid in that cycle, round-robin (same pointer) picks one to bypass. The others push into their own FIFOs normally.
  - Bypass is suppressed under clear.
- When undefined: the fixed 2-cycle path only.

Decomposition:
- Package cdb_pkg holds:
  - typedef cdb_entry_t: packed struct {result, rob, ctrl}.
  - Constants SRC_ALU=0, SRC_BRANCH=1.
  - Localparam for the cdb_src width.
- One natural sub-module: cdb_src_fifo.
  - Parameterised DEPTH, one instance per source.
  - Ports: push, pop, clear, entry in, head out, count/full/empty.
  - Same clk and globalReset.
- Arbitration and the output register stay in cdb_arbiter.

Test Plan:
- Reset, then ALU pushes {result=0x0000_00AA, rob=3, ctrl=0} with cdb_accept=1 -> cdb_valid=1 with result=0xAA, rob=3, cdb_src=0 two cycles after src_valid; cdb_valid=0 the following cycle.
- ALU and branch push every cycle for 6 cycles (rob 0..5 alternating per source), cdb_accept=1 -> CDB sources alternate 1,0,1,0…; per-source rob order preserved; no entry lost or duplicated.
- cdb_accept=0 held 4 cycles while ALU pushes 0x11, 0x22, 0x33 -> src_ready[0]=0 after 2 entries plus the output register are occupied; CDB holds 0x11 steady; on release the CDB emits 0x22 then 0x33.
- Both FIFOs full and CDB holding a word, then clear=1 together with src_valid=2'b11 -> next cycle cdb_valid=0, src_ready=2'b11, nothing from the clear cycle ever appears.
- globalReset=0 asserted mid-stream, with a pending output and non-empty FIFOs -> all outputs zero the next cycle; the first post-reset push behaves as in scenario 1.
- With CDB_BYPASS_EN defined, empty block, ALU pushes 0x55 rob=1 -> cdb_valid=1 one cycle after src_valid. Simultaneous ALU and branch push -> branch bypasses (ptr=0), ALU 0x66 appears the next cycle.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared types and constants for the CDB transmit-side arbiter.
package cdb_pkg;

  localparam int unsigned SRC_ALU      = 0;
  localparam int unsigned SRC_BRANCH   = 1;
  localparam int unsigned NSRC_DEFAULT = 2;

  // Width of a source index; never narrower than one bit.
  function automatic int unsigned srcWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned SRC_W = srcWidth(NSRC_DEFAULT);

  typedef struct packed {
    logic [31:0] result;
    logic [2:0]  rob;
    logic [1:0]  ctrl;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO; power-of-two DEPTH, registered count/full/empty.
module cdb_src_fifo #(
  parameter int unsigned EW    = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     globalReset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [EW-1:0]            entryIn,
  output logic [EW-1:0]            head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          doPush;
  logic          doPop;

  assign full   = (count == (AW + 1)'(DEPTH));
  assign empty  = (count == '0);
  assign head   = mem[rdPtr];
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!globalReset || clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define occupancy.
  always_ff @(posedge clk) begin
    if (globalReset && !clear && doPush) mem[wrPtr] <= entryIn;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB transmit side: per-source FIFOs, round-robin pick, one output register.
// Optional macro CDB_BYPASS_EN: load straight into the output register when all FIFOs are empty.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned WIDTH = 31,
  parameter int unsigned ROB   = 2,
  parameter int unsigned CTRL  = 1,
  parameter int unsigned NSRC  = 2,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       globalReset,
  input  logic                       clear,
  input  logic [NSRC-1:0]            src_valid,
  output logic [NSRC-1:0]            src_ready,
  input  logic [NSRC*(WIDTH+1)-1:0]  src_result,
  input  logic [NSRC*(ROB+1)-1:0]    src_rob,
  input  logic [NSRC*(CTRL+1)-1:0]   src_ctrl,
  input  logic                       cdb_accept,
  output logic                       cdb_valid,
  output logic [WIDTH:0]             cdb_result,
  output logic [ROB:0]               cdb_rob,
  output logic [CTRL:0]              cdb_ctrl,
  output logic [srcWidth(NSRC)-1:0]  cdb_src
);

  localparam int unsigned SW = srcWidth(NSRC);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [WIDTH:0] result;
    logic [ROB:0]   rob;
    logic [CTRL:0]  ctrl;
  } entry_t;

  localparam int unsigned EW = $bits(entry_t);

  entry_t          srcEntry  [NSRC];
  entry_t          headEntry [NSRC];
  logic [CW-1:0]   count     [NSRC];
  logic [NSRC-1:0] full;
  logic [NSRC-1:0] empty;
  logic [NSRC-1:0] push;
  logic [NSRC-1:0] pop;

  entry_t          outReg;
  logic [SW-1:0]   ptr;
  logic            outFree;
  logic [SW:0]     fifoPick;
  logic            doLoad;
  logic            doBypass;

  // Returns {found, index}; search starts one past the last winner.
  function automatic logic [SW:0] rrPick(input logic [NSRC-1:0] req, input logic [SW-1:0] last);
    logic [SW:0] res;
    logic        found;
    int unsigned idx;
    res   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NSRC; k++) begin
      idx = (32'(last) + k) % NSRC;
      if (!found && req[SW'(idx)]) begin
        found = 1'b1;
        res   = {1'b1, SW'(idx)};
      end
    end
    return res;
  endfunction

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    assign srcEntry[i] = '{result: src_result[i*(WIDTH+1) +: WIDTH+1],
                           rob:    src_rob[i*(ROB+1) +: ROB+1],
                           ctrl:   src_ctrl[i*(CTRL+1) +: CTRL+1]};
    assign src_ready[i] = (count[i] != CW'(DEPTH));

    cdb_src_fifo #(
      .EW    (EW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk         (clk),
      .globalReset (globalReset),
      .clear       (clear),
      .push        (push[i]),
      .pop         (pop[i]),
      .entryIn     (srcEntry[i]),
      .head        (headEntry[i]),
      .count       (count[i]),
      .full        (full[i]),
      .empty       (empty[i])
    );

    a_noPushFull : assert property (@(posedge clk) disable iff (!globalReset) !(push[i] && full[i]));
  end

  assign outFree  = !cdb_valid || cdb_accept;
  assign fifoPick = rrPick(~empty, ptr);
  assign doLoad   = outFree && fifoPick[SW] && !clear;

`ifdef CDB_BYPASS_EN
  logic [SW:0] bypPick;
  assign bypPick  = rrPick(src_valid, ptr);
  assign doBypass = outFree && (&empty) && bypPick[SW] && !clear;
`else
  assign doBypass = 1'b0;
`endif

  always_comb begin
    push = src_valid & src_ready;
    pop  = '0;
    if (doLoad) pop[fifoPick[SW-1:0]] = 1'b1;
`ifdef CDB_BYPASS_EN
    // The bypassed source goes straight to the output and must not also enqueue.
    if (doBypass) push[bypPick[SW-1:0]] = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!globalReset) begin
      cdb_valid <= 1'b0;
      outReg    <= '0;
      cdb_src   <= '0;
      ptr       <= '0;
    end else if (clear) begin
      cdb_valid <= 1'b0;
      ptr       <= '0;
`ifdef CDB_BYPASS_EN
    end else if (doBypass) begin
      cdb_valid <= 1'b1;
      outReg    <= srcEntry[bypPick[SW-1:0]];
      cdb_src   <= bypPick[SW-1:0];
      ptr       <= bypPick[SW-1:0];
`endif
    end else if (doLoad) begin
      cdb_valid <= 1'b1;
      outReg    <= headEntry[fifoPick[SW-1:0]];
      cdb_src   <= fifoPick[SW-1:0];
      ptr       <= fifoPick[SW-1:0];
    end else if (outFree) begin
      cdb_valid <= 1'b0;
    end
  end

  assign cdb_result = outReg.result;
  assign cdb_rob    = outReg.rob;
  assign cdb_ctrl   = outReg.ctrl;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (default parameters).
module tb_cdb_arbiter;
  import cdb_pkg::*;

`ifdef CDB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        globalReset;
  logic        clear;
  logic [1:0]  src_valid;
  logic [1:0]  src_ready;
  logic [63:0] src_result;
  logic [5:0]  src_rob;
  logic [3:0]  src_ctrl;
  logic        cdb_accept;
  logic        cdb_valid;
  logic [31:0] cdb_result;
  logic [2:0]  cdb_rob;
  logic [1:0]  cdb_ctrl;
  logic [0:0]  cdb_src;

  int checks   = 0;
  int failures = 0;

  cdb_arbiter #(
    .WIDTH (31),
    .ROB   (2),
    .CTRL  (1),
    .NSRC  (2),
    .DEPTH (2)
  ) dut (
    .clk         (clk),
    .globalReset (globalReset),
    .clear       (clear),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .src_result  (src_result),
    .src_rob     (src_rob),
    .src_ctrl    (src_ctrl),
    .cdb_accept  (cdb_accept),
    .cdb_valid   (cdb_valid),
    .cdb_result  (cdb_result),
    .cdb_rob     (cdb_rob),
    .cdb_ctrl    (cdb_ctrl),
    .cdb_src     (cdb_src)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setSrc(input int s, input logic v, input logic [31:0] r,
                        input logic [2:0] rb, input logic [1:0] c);
    src_valid[s]         = v;
    src_result[s*32 +: 32] = r;
    src_rob[s*3 +: 3]    = rb;
    src_ctrl[s*2 +: 2]   = c;
  endtask

  task automatic doReset();
    globalReset = 1'b0;
    clear       = 1'b0;
    src_valid   = '0;
    src_result  = '0;
    src_rob     = '0;
    src_ctrl    = '0;
    cdb_accept  = 1'b1;
    tick();
    tick();
    globalReset = 1'b1;
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %0b expected 0", cdb_valid); end
    checks++; if (cdb_result !== 32'h0) begin failures++; $display("FAIL rst_result: got %h expected 0", cdb_result); end
    checks++; if (cdb_rob !== 3'd0) begin failures++; $display("FAIL rst_rob: got %0d expected 0", cdb_rob); end
    checks++; if (cdb_ctrl !== 2'd0) begin failures++; $display("FAIL rst_ctrl: got %0d expected 0", cdb_ctrl); end
    checks++; if (cdb_src !== 1'b0) begin failures++; $display("FAIL rst_src: got %0d expected 0", cdb_src); end
    checks++; if (src_ready !== 2'b11) begin failures++; $display("FAIL rst_ready: got %b expected 11", src_ready); end
  endtask

  // ALU pushes 0xAA/rob 3 once; caller has just left reset.
  task automatic test_single_push();
    setSrc(SRC_ALU, 1'b1, 32'h0000_00AA, 3'd3, 2'd0);
    for (int c = 1; c <= LAT; c++) begin
      tick();
      if (c == 1) src_valid = '0;
      if (c < LAT) begin
        checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL single_early: got %0b expected 0", cdb_valid); end
      end
    end
    checks++; if (cdb_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %0b expected 1", cdb_valid); end
    checks++; if (cdb_result !== 32'hAA) begin failures++; $display("FAIL single_result: got %h expected 000000aa", cdb_result); end
    checks++; if (cdb_rob !== 3'd3) begin failures++; $display("FAIL single_rob: got %0d expected 3", cdb_rob); end
    checks++; if (cdb_src !== 1'(SRC_ALU)) begin failures++; $display("FAIL single_src: got %0d expected 0", cdb_src); end
    tick();
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL single_drain: got %0b expected 0", cdb_valid); end
  endtask

`ifndef CDB_BYPASS_EN
  // Both sources stream 6 entries each; output must alternate branch, ALU, ...
  task automatic test_back_to_back();
    int ia, ib, nout;
    logic accA, accB;
    logic [31:0] er;
    logic [2:0]  erob;
    logic [0:0]  es;
    doReset();
    ia = 0; ib = 0; nout = 0;
    setSrc(SRC_ALU, 1'b1, 32'h100, 3'd0, 2'd0);
    setSrc(SRC_BRANCH, 1'b1, 32'h200, 3'd0, 2'd2);
    for (int cyc = 0; cyc < 40 && nout < 12; cyc++) begin
      accA = src_valid[0] && src_ready[0];
      accB = src_valid[1] && src_ready[1];
      tick();
      if (accA) ia++;
      if (accB) ib++;
      if (cdb_valid) begin
        es   = (nout % 2 == 0) ? 1'(SRC_BRANCH) : 1'(SRC_ALU);
        erob = 3'(nout / 2);
        er   = ((nout % 2 == 0) ? 32'h200 : 32'h100) + 32'(nout / 2);
        checks++;
        if ({cdb_src, cdb_rob, cdb_result} !== {es, erob, er}) begin
          failures++;
          $display("FAIL b2b_word%0d: got src=%0d rob=%0d res=%h expected src=%0d rob=%0d res=%h",
                   nout, cdb_src, cdb_rob, cdb_result, es, erob, er);
        end
        nout++;
      end
      setSrc(SRC_ALU, ia < 6, 32'h100 + 32'(ia), 3'(ia), 2'd0);
      setSrc(SRC_BRANCH, ib < 6, 32'h200 + 32'(ib), 3'(ib), 2'd2);
    end
    checks++; if (nout != 12) begin failures++; $display("FAIL b2b_count: got %0d expected 12", nout); end
    tick();
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL b2b_extra: got valid %0b expected 0", cdb_valid); end
  endtask
`endif

  task automatic test_backpressure();
    doReset();
    cdb_accept = 1'b0;
    setSrc(SRC_ALU, 1'b1, 32'h11, 3'd1, 2'd0);
    tick();
    setSrc(SRC_ALU, 1'b1, 32'h22, 3'd2, 2'd0);
    tick();
    checks++; if (cdb_valid !== 1'b1 || cdb_result !== 32'h11) begin failures++; $display("FAIL bp_first: got v=%0b res=%h expected v=1 res=00000011", cdb_valid, cdb_result); end
    setSrc(SRC_ALU, 1'b1, 32'h33, 3'd3, 2'd0);
    tick();
    src_valid = '0;
    checks++; if (src_ready[0] !== 1'b0) begin failures++; $display("FAIL bp_ready_full: got %0b expected 0", src_ready[0]); end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (cdb_valid !== 1'b1 || cdb_result !== 32'h11 || src_ready[0] !== 1'b0) begin
        failures++; $display("FAIL bp_hold%0d: got v=%0b res=%h rdy=%0b expected v=1 res=00000011 rdy=0", c, cdb_valid, cdb_result, src_ready[0]);
      end
    end
    cdb_accept = 1'b1;
    tick();
    checks++; if (cdb_valid !== 1'b1 || cdb_result !== 32'h22) begin failures++; $display("FAIL bp_second: got v=%0b res=%h expected v=1 res=00000022", cdb_valid, cdb_result); end
    checks++; if (src_ready[0] !== 1'b1) begin failures++; $display("FAIL bp_ready_back: got %0b expected 1", src_ready[0]); end
    tick();
    checks++; if (cdb_valid !== 1'b1 || cdb_result !== 32'h33) begin failures++; $display("FAIL bp_third: got v=%0b res=%h expected v=1 res=00000033", cdb_valid, cdb_result); end
    tick();
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL bp_drain: got %0b expected 0", cdb_valid); end
  endtask

  task automatic test_clear_flush();
    doReset();
    cdb_accept = 1'b0;
    for (int k = 0; k < 3; k++) begin
      setSrc(SRC_ALU, 1'b1, 32'hA0 + 32'(k), 3'(k), 2'd0);
      setSrc(SRC_BRANCH, 1'b1, 32'hB0 + 32'(k), 3'(k + 4), 2'd1);
      tick();
    end
    checks++; if (src_ready !== 2'b00 || cdb_valid !== 1'b1) begin failures++; $display("FAIL clr_full: got rdy=%b v=%0b expected rdy=00 v=1", src_ready, cdb_valid); end
    clear = 1'b1;
    setSrc(SRC_ALU, 1'b1, 32'hDEAD, 3'd7, 2'd3);
    setSrc(SRC_BRANCH, 1'b1, 32'hBEEF, 3'd6, 2'd3);
    tick();
    clear = 1'b0;
    src_valid = '0;
    cdb_accept = 1'b1;
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL clr_valid: got %0b expected 0", cdb_valid); end
    checks++; if (src_ready !== 2'b11) begin failures++; $display("FAIL clr_ready: got %b expected 11", src_ready); end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL clr_leak%0d: got v=%0b res=%h expected v=0", c, cdb_valid, cdb_result); end
    end
  endtask

  task automatic test_midstream_reset();
    doReset();
    cdb_accept = 1'b0;
    for (int k = 0; k < 3; k++) begin
      setSrc(SRC_ALU, 1'b1, 32'h40 + 32'(k), 3'(k + 1), 2'd1);
      setSrc(SRC_BRANCH, 1'b1, 32'h50 + 32'(k), 3'(k + 2), 2'd2);
      tick();
    end
    src_valid = '0;
    checks++; if (cdb_valid !== 1'b1) begin failures++; $display("FAIL mrst_pending: got %0b expected 1", cdb_valid); end
    globalReset = 1'b0;
    tick();
    checks++; if ({cdb_valid, cdb_result, cdb_rob, cdb_ctrl, cdb_src} !== '0) begin
      failures++; $display("FAIL mrst_zero: got v=%0b res=%h rob=%0d ctrl=%0d src=%0d expected all 0", cdb_valid, cdb_result, cdb_rob, cdb_ctrl, cdb_src);
    end
    checks++; if (src_ready !== 2'b11) begin failures++; $display("FAIL mrst_ready: got %b expected 11", src_ready); end
    globalReset = 1'b1;
    cdb_accept = 1'b1;
    test_single_push();
  endtask

`ifdef CDB_BYPASS_EN
  task automatic test_bypass();
    doReset();
    setSrc(SRC_ALU, 1'b1, 32'h55, 3'd1, 2'd0);
    tick();
    src_valid = '0;
    checks++; if (cdb_valid !== 1'b1 || cdb_result !== 32'h55 || cdb_rob !== 3'd1) begin
      failures++; $display("FAIL byp_single: got v=%0b res=%h rob=%0d expected v=1 res=00000055 rob=1", cdb_valid, cdb_result, cdb_rob);
    end
    tick();
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL byp_drain: got %0b expected 0", cdb_valid); end
    setSrc(SRC_ALU, 1'b1, 32'h66, 3'd2, 2'd0);
    setSrc(SRC_BRANCH, 1'b1, 32'h77, 3'd3, 2'd2);
    tick();
    src_valid = '0;
    checks++; if (cdb_valid !== 1'b1 || cdb_result !== 32'h77 || cdb_src !== 1'(SRC_BRANCH)) begin
      failures++; $display("FAIL byp_branch: got v=%0b res=%h src=%0d expected v=1 res=00000077 src=1", cdb_valid, cdb_result, cdb_src);
    end
    tick();
    checks++; if (cdb_valid !== 1'b1 || cdb_result !== 32'h66 || cdb_src !== 1'(SRC_ALU)) begin
      failures++; $display("FAIL byp_alu: got v=%0b res=%h src=%0d expected v=1 res=00000066 src=0", cdb_valid, cdb_result, cdb_src);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_push();
`ifndef CDB_BYPASS_EN
    test_back_to_back();
`endif
    test_backpressure();
    test_clear_flush();
    test_midstream_reset();
`ifdef CDB_BYPASS_EN
    test_bypass();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
